// File: rtl/regfile_check_unit_pkg.sv
// Shared types, constants and helpers for the register-file self-check unit.
package regfile_check_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_NUM_REGS    = 32'd32;
    localparam int unsigned DEF_DATA_WIDTH  = 32'd32;
    localparam int unsigned DEF_CYCLE_LIMIT = 32'd50;
    localparam int unsigned DEF_CNT_WIDTH   = 32'd16;
    localparam int unsigned DEF_ERR_WIDTH   = 32'd8;
    localparam int unsigned DEF_SKIP_R0     = 32'd1;

    // Smallest w with 2**w >= value; used for register index widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_check_unit_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module regfile_check_unit_sat_counter #(
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register: clear has priority, increment stops at the maximum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != '1)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/regfile_check_unit.sv
// Runs the processor for a set number of unheld cycles, then walks the register
// file comparing each entry with an expected table, reporting errors on pins.
module regfile_check_unit
    import regfile_check_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned CYCLE_LIMIT = DEF_CYCLE_LIMIT,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned ERR_WIDTH   = DEF_ERR_WIDTH,
    parameter int unsigned SKIP_R0     = DEF_SKIP_R0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       hold,
    output logic [clog2(NUM_REGS)-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0]      rf_data,
    output logic [clog2(NUM_REGS)-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0]      exp_data,
    input  logic                       exp_check,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_WIDTH-1:0]       err_count,
    output logic                       mismatch,
    output logic [clog2(NUM_REGS)-1:0] mismatch_reg,
    output logic                       first_err_valid,
    output logic [clog2(NUM_REGS)-1:0] first_err_reg,
    output logic [DATA_WIDTH-1:0]      first_err_exp,
    output logic [DATA_WIDTH-1:0]      first_err_got
);

    localparam int unsigned IDX_W = clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_R0 != 32'd0) ? IDX_W'(1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 32'd1);
    localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(CYCLE_LIMIT - 32'd1);

    if (CYCLE_LIMIT == 32'd0) begin : g_bad_cycle_limit
        $error("regfile_check_unit: CYCLE_LIMIT must be at least 1");
    end
    if (NUM_REGS < 32'd2) begin : g_bad_num_regs
        $error("regfile_check_unit: NUM_REGS must be at least 2");
    end

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_WIDTH-1:0]   run_cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   start_ok_s;
    logic                   run_end_s;
    logic                   scan_end_s;
    logic                   cmp_s;
    logic                   busy_r;
    logic                   done_r;
    logic                   mismatch_r;
    logic [IDX_W-1:0]       mismatch_reg_r;
    logic                   first_valid_r;
    logic [IDX_W-1:0]       first_reg_r;
    logic [DATA_WIDTH-1:0]  first_exp_r;
    logic [DATA_WIDTH-1:0]  first_got_r;
    logic [ERR_WIDTH-1:0]   err_cnt_s;

    // Next-state logic and the per-cycle compare strobe.
    always_comb begin
        state_nxt_s = state_r;
        start_ok_s  = 1'b0;
        run_end_s   = 1'b0;
        scan_end_s  = 1'b0;
        cmp_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    start_ok_s  = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                // A held terminal count must not advance into the scan.
                if (!hold && (run_cnt_r == RUN_LAST)) begin
                    state_nxt_s = ST_SCAN;
                    run_end_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SCAN: begin
                cmp_s = exp_check && (rf_data != exp_data);
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DONE;
                    scan_end_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, run counter, scan index and the busy/done flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            run_cnt_r <= '0;
            idx_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_SCAN);
            done_r  <= (state_nxt_s == ST_DONE);
            if (start_ok_s) begin
                run_cnt_r <= '0;
            end else if ((state_r == ST_RUN) && !hold) begin
                run_cnt_r <= run_cnt_r + CNT_WIDTH'(1);
            end else begin
                run_cnt_r <= run_cnt_r;
            end
            if (start_ok_s) begin
                idx_r <= '0;
            end else if (run_end_s) begin
                idx_r <= FIRST_IDX;
            end else if ((state_r == ST_SCAN) && !scan_end_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Mismatch pulse, last-mismatch index and first-failure capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mismatch_r     <= 1'b0;
            mismatch_reg_r <= '0;
            first_valid_r  <= 1'b0;
            first_reg_r    <= '0;
            first_exp_r    <= '0;
            first_got_r    <= '0;
        end else begin
            mismatch_r <= cmp_s;
            if (start_ok_s) begin
                mismatch_reg_r <= '0;
                first_valid_r  <= 1'b0;
                first_reg_r    <= '0;
                first_exp_r    <= '0;
                first_got_r    <= '0;
            end else if (cmp_s) begin
                mismatch_reg_r <= idx_r;
                if (!first_valid_r) begin
                    first_valid_r <= 1'b1;
                    first_reg_r   <= idx_r;
                    first_exp_r   <= exp_data;
                    first_got_r   <= rf_data;
                end else begin
                    first_valid_r <= first_valid_r;
                end
            end else begin
                mismatch_reg_r <= mismatch_reg_r;
                first_valid_r  <= first_valid_r;
            end
        end
    end

    regfile_check_unit_sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_ok_s),
        .enable (cmp_s),
        .count  (err_cnt_s)
    );

    assign rf_addr         = idx_r;
    assign exp_addr        = idx_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = done_r && (err_cnt_s == '0);
    assign err_count       = err_cnt_s;
    assign mismatch        = mismatch_r;
    assign mismatch_reg    = mismatch_reg_r;
    assign first_err_valid = first_valid_r;
    assign first_err_reg   = first_reg_r;
    assign first_err_exp   = first_exp_r;
    assign first_err_got   = first_got_r;

endmodule

// File: tb/tb_regfile_check_unit.sv
// Self-checking bench: directed vector table plus randomized runs against a
// cycle-counting reference model of the run/scan rules.
module tb_regfile_check_unit;

    localparam int NR       = 32;
    localparam int DW       = 32;
    localparam int CL       = 50;
    localparam int EW       = 3;
    localparam int IW       = 5;
    localparam int FIRST    = 1;
    localparam int SAT      = 7;
    localparam int BUDGET   = 2000;

    typedef struct {
        int          corrupt;   // -1 none, -2 every scanned entry checked and wrong
        logic [31:0] flip;
        bit          force_chk;
        int          hold_mode; // 0 none, 1 random, 2 ten cycles early in RUN
        bit          start_mid;
        int          exp_err;
        bit          exp_fev;
        int          exp_reg;
        logic [31:0] exp_exp;
        logic [31:0] exp_got;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          hold  = 1'b0;
    logic [IW-1:0] rf_addr, exp_addr, mismatch_reg, first_err_reg;
    logic [DW-1:0] rf_data, exp_data, first_err_exp, first_err_got;
    logic          exp_check, busy, done, pass, mismatch, first_err_valid;
    logic [EW-1:0] err_count;

    logic [DW-1:0] rf_mem  [NR];
    logic [DW-1:0] ex_mem  [NR];
    logic          chk_mem [NR];

    int checks = 0;
    int errors = 0;

    assign rf_data   = rf_mem[rf_addr];
    assign exp_data  = ex_mem[exp_addr];
    assign exp_check = chk_mem[exp_addr];

    always #5 clock = ~clock;

    regfile_check_unit #(
        .NUM_REGS(NR), .DATA_WIDTH(DW), .CYCLE_LIMIT(CL),
        .CNT_WIDTH(16), .ERR_WIDTH(EW), .SKIP_R0(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .hold(hold),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_check(exp_check),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .mismatch(mismatch), .mismatch_reg(mismatch_reg),
        .first_err_valid(first_err_valid), .first_err_reg(first_err_reg),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_mm"}, mismatch, 0);
        check({tag, "_rfaddr"}, rf_addr, 0);
        check({tag, "_mreg"}, mismatch_reg, 0);
        check({tag, "_fev"}, first_err_valid, 0);
        check({tag, "_freg"}, first_err_reg, 0);
        check({tag, "_fexp"}, first_err_exp, 0);
        check({tag, "_fgot"}, first_err_got, 0);
    endtask

    task automatic setup_base();
        for (int i = 0; i < NR; i++) begin
            ex_mem[i]  = $urandom;
            rf_mem[i]  = $urandom;
            chk_mem[i] = 1'b0;
        end
        ex_mem[1] = 32'd7; ex_mem[2] = 32'd7; ex_mem[3] = 32'd7; ex_mem[4] = 32'd0;
        ex_mem[5] = 32'd0; ex_mem[6] = 32'd6; ex_mem[7] = 32'd7; ex_mem[15] = 32'd6;
        for (int i = 1; i < 16; i++) begin
            if (i <= 7 || i == 15) begin
                chk_mem[i] = 1'b1;
                rf_mem[i]  = ex_mem[i];
            end
        end
    endtask

    // Reference summary straight from the rules: entries 1..NR-1 that are
    // checked and differ are failures, in ascending index order.
    task automatic model(output int cnt, output int first, output int last,
                         output logic [31:0] fexp, output logic [31:0] fgot);
        cnt = 0; first = 0; last = 0; fexp = '0; fgot = '0;
        for (int i = FIRST; i < NR; i++) begin
            if (chk_mem[i] && (rf_mem[i] != ex_mem[i])) begin
                if (cnt == 0) begin
                    first = i; fexp = ex_mem[i]; fgot = rf_mem[i];
                end
                cnt++;
                last = i;
            end
        end
    endtask

    task automatic run_once(input string tag, input int hold_mode, input bit start_mid);
        int unheld, idx, phase, n;
        bit h, mm;
        n = 0; unheld = 0; idx = 0; phase = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_state"}, {busy, done, pass}, 3'b100);
        check({tag, "_start_err"}, err_count, 0);
        check({tag, "_start_fev"}, first_err_valid, 0);
        check({tag, "_start_mreg"}, mismatch_reg, 0);
        while (phase != 3 && n < BUDGET) begin
            case (hold_mode)
                1:       h = ($urandom_range(0, 2) == 0);
                2:       h = (n >= 5 && n < 15);
                default: h = 1'b0;
            endcase
            hold  = h;
            start = start_mid && (n == 20);
            tick();
            n++;
            hold  = 1'b0;
            start = 1'b0;
            if (phase == 1) begin
                check({tag, "_run_mm"}, mismatch, 0);
                check({tag, "_run_state"}, {busy, done}, 2'b10);
                if (!h) unheld++;
                if (unheld == CL) begin
                    phase = 2;
                    idx = FIRST;
                    check({tag, "_scan_first_addr"}, rf_addr, idx);
                    check({tag, "_scan_exp_addr"}, exp_addr, idx);
                end
            end else begin
                mm = chk_mem[idx] && (rf_mem[idx] != ex_mem[idx]);
                check({tag, "_mm_pulse"}, mismatch, mm);
                if (mm) check({tag, "_mm_reg"}, mismatch_reg, idx);
                if (idx == NR - 1) begin
                    phase = 3;
                    check({tag, "_done_rise"}, {busy, done}, 2'b01);
                end else begin
                    idx++;
                    check({tag, "_scan_addr"}, rf_addr, idx);
                    check({tag, "_scan_state"}, {busy, done}, 2'b10);
                end
            end
        end
        check({tag, "_finished"}, phase, 3);
    endtask

    task automatic final_check(input string tag, input int err, input bit fev, input int freg,
                               input logic [31:0] fexp, input logic [31:0] fgot, input int last);
        check({tag, "_err_count"}, err_count, err);
        check({tag, "_pass"}, pass, (err == 0));
        check({tag, "_fev"}, first_err_valid, fev);
        check({tag, "_first_reg"}, first_err_reg, freg);
        check({tag, "_first_exp"}, first_err_exp, fexp);
        check({tag, "_first_got"}, first_err_got, fgot);
        check({tag, "_last_mreg"}, mismatch_reg, last);
        tick();
        check({tag, "_done_hold"}, {busy, done, mismatch}, 3'b010);
        check({tag, "_err_hold"}, err_count, err);
    endtask

    vec_t vecs [9];

    initial begin
        int cnt, first, last, guard;
        logic [31:0] fexp, fgot;
        vec_t v;

        vecs[0] = '{-1, 32'h0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 32'd0, 32'd0};
        vecs[1] = '{6, 32'h3, 1'b0, 0, 1'b0, 1, 1'b1, 6, 32'd6, 32'd5};
        vecs[2] = '{-1, 32'h0, 1'b0, 2, 1'b0, 0, 1'b0, 0, 32'd0, 32'd0};
        vecs[3] = '{15, 32'h6, 1'b0, 0, 1'b0, 1, 1'b1, 15, 32'd6, 32'd0};
        vecs[4] = '{9, 32'h123, 1'b0, 0, 1'b0, 0, 1'b0, 0, 32'd0, 32'd0};
        vecs[5] = '{0, 32'h1, 1'b1, 0, 1'b0, 0, 1'b0, 0, 32'd0, 32'd0};
        vecs[6] = '{31, 32'h8000_0000, 1'b1, 0, 1'b0, 1, 1'b1, 31, 32'hA5A5_0000, 32'h25A5_0000};
        vecs[7] = '{-2, 32'h1, 1'b0, 0, 1'b0, 7, 1'b1, 1, 32'd7, 32'd6};
        vecs[8] = '{-1, 32'h0, 1'b0, 1, 1'b1, 0, 1'b0, 0, 32'd0, 32'd0};

        setup_base();
        #2;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("idle");

        // Directed table; vector 8 follows a failing run so its start also
        // exercises the restart-from-DONE clearing.
        for (int k = 0; k < 9; k++) begin
            v = vecs[k];
            setup_base();
            if (v.corrupt == -2) begin
                for (int i = FIRST; i < NR; i++) begin
                    chk_mem[i] = 1'b1;
                    rf_mem[i]  = ex_mem[i] ^ v.flip;
                end
            end else if (v.corrupt >= 0) begin
                if (v.force_chk) begin
                    chk_mem[v.corrupt] = 1'b1;
                    ex_mem[v.corrupt]  = 32'hA5A5_0000;
                end
                rf_mem[v.corrupt] = ex_mem[v.corrupt] ^ v.flip;
            end
            model(cnt, first, last, fexp, fgot);
            run_once($sformatf("v%0d", k), v.hold_mode, v.start_mid);
            final_check($sformatf("v%0d", k), v.exp_err, v.exp_fev, v.exp_reg,
                        v.exp_exp, v.exp_got, last);
        end

        // Asynchronous reset in the middle of the scan.
        setup_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(busy && rf_addr == 5'd9) && guard < 200) begin
            tick();
            guard++;
        end
        check("reach_idx9", rf_addr, 9);
        reset = 1'b0;
        #1;
        check_all_zero("midscan_reset");
        tick();
        check_all_zero("midscan_reset_held");
        reset = 1'b1;
        tick();
        check_all_zero("after_reset_idle");
        model(cnt, first, last, fexp, fgot);
        run_once("post_reset", 0, 1'b0);
        final_check("post_reset", 0, 1'b0, 0, 32'd0, 32'd0, 0);

        // Randomized tables and hold patterns against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) begin
                ex_mem[i]  = $urandom;
                chk_mem[i] = ($urandom_range(0, 1) == 1);
                rf_mem[i]  = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd0) : ex_mem[i];
            end
            model(cnt, first, last, fexp, fgot);
            run_once($sformatf("rnd%0d", r), 1, 1'b0);
            final_check($sformatf("rnd%0d", r), (cnt > SAT) ? SAT : cnt, (cnt > 0),
                        first, fexp, fgot, last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
